// File: rtl/pc_unit_if.sv
// Fetch-side bus of the program-counter unit: control inputs and PC/RAS status outputs.
// The master drives stall/PS/in, and the pc_unit (slave) returns PC and stack state.
interface pc_unit_if #(
    parameter int unsigned N     = 64,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic          stall;
    logic [2:0]    PS;
    logic [N-1:0]  in;
    logic [N-1:0]  PC;
    logic [N-1:0]  PC4;
    logic [CW-1:0] ras_count;
    logic [N-1:0]  ras_top;
    logic          ras_overflow;
    logic          ras_underflow;

    modport master (
        output stall, PS, in,
        input  PC, PC4, ras_count, ras_top, ras_overflow, ras_underflow
    );

    modport slave (
        input  stall, PS, in,
        output PC, PC4, ras_count, ras_top, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/pc_unit.sv
// Program counter with sequential/branch/jump targets and a circular return-address
// stack that keeps the newest DEPTH links, with sticky overflow/underflow status.
module pc_unit #(
    parameter int unsigned   N        = 64,
    parameter int unsigned   DEPTH    = 8,
    parameter logic [N-1:0]  RESET_PC = '0
) (
    input  logic       clock,
    input  logic       reset,
    pc_unit_if.slave   bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        PS_HOLD     = 3'b000,
        PS_SEQ      = 3'b001,
        PS_JUMP     = 3'b010,
        PS_BRANCH   = 3'b011,
        PS_CALL     = 3'b100,
        PS_RETURN   = 3'b101,
        PS_CALL_ABS = 3'b110,
        PS_RSVD     = 3'b111
    } ps_e;

    logic [N-1:0]  pc_q;
    logic [PW-1:0] ptr_q;
    logic [CW-1:0] count_q;
    logic          ovf_q;
    logic          udf_q;
    logic [N-1:0]  stack [DEPTH];

    logic [N-1:0]  pc4;
    logic [N-1:0]  rel_target;
    logic [N-1:0]  top;
    logic [N-1:0]  pc_d;
    logic [PW-1:0] ptr_inc;
    logic [PW-1:0] ptr_dec;
    logic          push;
    logic          pop;
    logic          set_udf;
    logic          full;
    logic          empty;
    ps_e           ps;

    assign ps         = ps_e'(bus.PS);
    assign pc4        = pc_q + N'(4);
    assign rel_target = pc4 + {bus.in[N-3:0], 2'b00};
    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign top        = empty ? '0 : stack[ptr_q];

    // Pointer wraps explicitly so non-power-of-two depths stay in range.
    assign ptr_inc = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
    assign ptr_dec = (ptr_q == '0) ? PW'(DEPTH - 1) : ptr_q - PW'(1);

    always_comb begin
        pc_d    = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        set_udf = 1'b0;
        unique case (ps)
            PS_HOLD:     pc_d = pc_q;
            PS_SEQ:      pc_d = pc4;
            PS_JUMP:     pc_d = bus.in;
            PS_BRANCH:   pc_d = rel_target;
            PS_CALL: begin
                pc_d = rel_target;
                push = 1'b1;
            end
            PS_RETURN: begin
                if (!empty) begin
                    pc_d = top;
                    pop  = 1'b1;
                end else begin
                    pc_d    = bus.in;
                    set_udf = 1'b1;
                end
            end
            PS_CALL_ABS: begin
                pc_d = bus.in;
                push = 1'b1;
            end
            PS_RSVD:     pc_d = pc_q;
            default:     pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            ptr_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else if (!bus.stall) begin
            pc_q <= pc_d;
            if (push) begin
                ptr_q <= ptr_inc;
                if (full) ovf_q <= 1'b1;
                else      count_q <= count_q + CW'(1);
            end else if (pop) begin
                ptr_q   <= ptr_dec;
                count_q <= count_q - CW'(1);
            end
            if (set_udf) udf_q <= 1'b1;
        end
    end

    // Storage has no reset; entries are only visible once counted as valid.
    always_ff @(posedge clock) begin
        if (!reset && !bus.stall && push) begin
            stack[ptr_inc] <= pc4;
        end
    end

    assign bus.PC            = pc_q;
    assign bus.PC4           = pc4;
    assign bus.ras_count     = count_q;
    assign bus.ras_top       = top;
    assign bus.ras_overflow  = ovf_q;
    assign bus.ras_underflow = udf_q;
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit with an integrated return-address stack (RAS). It sits at the front of the fetch stage and replaces the fixed 64-bit, four-function PC. It holds the PC register, computes sequential and branch targets, and services call/return by pushing and popping link addresses. Stall and overflow/underflow status are added for the control unit.

## Interface
- `N`, 64: PC and address width in bits (≥ 8).
- `DEPTH`, 8: RAS entries (≥ 2).
- `RESET_PC`, 0: PC value loaded on reset.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  when 1, no architectural state changes this cycle.
- `PS`  in  3  PC function select (see Operation).
- `in`  in  N  absolute target, or signed word offset, depending on `PS`.
- `PC`  out  N  current PC (registered).
- `PC4`  out  N  `PC + 4` (combinational, modulo 2^N).
- `ras_count`  out  clog2(DEPTH+1)  valid RAS entries.
- `ras_top`  out  N  top RAS entry; 0 when empty.
- `ras_overflow`  out  1  sticky: a push occurred while full.
- `ras_underflow`  out  1  sticky: a pop occurred while empty.

## Operation
- `PS` functions (effect applied at the clock edge):
  - 000 hold: PC <- PC.
  - 001 seq: PC <- PC4.
  - 010 jump: PC <- in.
  - 011 branch: PC <- PC4 + (in << 2).
  - 100 call: PC <- PC4 + (in << 2); push PC4.
  - 101 return: if not empty, PC <- ras_top and pop. If empty, PC <- in, set ras_underflow, count stays 0.
  - 110 call-abs: PC <- in; push PC4.
  - 111 reserved: behaves as hold; no stack change.
- Arithmetic:
  - `in << 2` is `{in[N-3:0], 2'b00}`, which treats `in` as a signed two's-complement word offset.
  - All sums wrap modulo 2^N. No carry or overflow is reported.
- RAS:
  - Circular buffer with a top pointer.
  - Push when not full: write PC4 at top+1 and increment count.
  - Push when full: overwrite the oldest entry (the pointer wraps). Count stays DEPTH and ras_overflow is set.
  - Pop: decrement count and move the pointer back.
  - Only the most recent DEPTH return addresses are retained.
- `stall`=1 overrides `PS`: PC, RAS contents, pointer, count and flags are all unchanged.
- Sticky flags clear only on reset.

## Timing
- Reset values, present after the first rising edge with `reset`=1:
  - PC = RESET_PC and PC4 = RESET_PC+4.
  - ras_count = 0 and ras_top = 0.
  - Both flags = 0 and the pointer = 0.
  - RAS storage contents are don't-care.
- Reset has priority over `stall` and `PS`. Reset asserted mid-sequence (e.g. with a call pending) discards the push.
- Latency:
  - The new PC is visible one cycle after the edge that samples `PS`.
  - PC4 follows PC combinationally in the same cycle.
- Back-to-back operations:
  - A call at edge k makes its push visible on ras_top/ras_count after edge k, so a return at edge k+1 pops it.
  - Each cycle performs at most one stack operation, so no simultaneous push+pop is possible.
- ras_top and ras_count are registered-state outputs (combinational read of the current top) and carry no extra latency.

## Test plan
- Reset and sequential: RESET_PC=0x1000; reset 1 cycle, then PS=001 for 3 cycles -> PC = 0x1000, 0x1004, 0x1008, 0x100C; PC4 always equals PC+4.
- Branch and wrap:
  - At PC=0x1000, PS=011 with in=-2 (all ones...FE) -> PC=0x0FFC.
  - At PC=2^N-4, PS=001 -> PC=0.
  - PS=010 with in=0x2000 -> PC=0x2000.
- Nested call/return: from PC=0x100, call (in=0x10) -> PC=0x144, ras_top=0x104, ras_count=1. A second call, then two returns -> PC returns to the second link, then to 0x104, and ras_count=0.
- Overflow: DEPTH=8, execute 9 calls -> ras_count=8 and ras_overflow=1. 8 returns then yield the last 8 links in LIFO order. A 9th return with in=0x500 -> PC=0x500 and ras_underflow=1.
- Stall: with ras_count=2, assert stall with PS=100, then with PS=101, 3 cycles each -> PC, ras_count and ras_top are unchanged. Deassert stall -> the operation executes normally.
- Reset mid-operation and reserved code: PS=111 -> PC holds. Assert reset while PS=100 and ras_count=3 -> PC=RESET_PC, ras_count=0, flags cleared.
